// File: rtl/pattern_load_sched.sv
// Field-write scheduler in front of patternbuffer: shares its single field port between the
// pat processor (always wins) and a byte-stream loader that fills a wrapping run of fields.
module pattern_load_sched #(
  parameter int buffer_size  = 22,
  parameter int buffer_width = 8,
  parameter int no_bufs      = 8,
  parameter int idx_w        = 5,
  parameter bit allow_live   = 1'b0,
  localparam int buf_w       = $clog2(no_bufs)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [buf_w-1:0]        pat_bufp,
  input  logic [buffer_size-1:0]  pat_fieldp,
  input  logic [buffer_size-1:0]  pat_fieldwp,
  input  logic [buffer_width-1:0] pat_field_in,
  input  logic                    pat_field_write,
  input  logic                    load_start,
  input  logic [buf_w-1:0]        load_buf,
  input  logic [idx_w-1:0]        load_first,
  input  logic [idx_w-1:0]        load_count,
  input  logic [buffer_width-1:0] s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic                    load_busy,
  output logic                    load_done,
  output logic                    load_err,
  output logic [buf_w-1:0]        bufp_out,
  output logic [buffer_size-1:0]  fieldp_out,
  output logic [buffer_size-1:0]  fieldwp_out,
  output logic [buffer_width-1:0] field_in_out,
  output logic                    field_write_out
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DONE
  } state_e;

  localparam logic [idx_w-1:0]       last_idx     = idx_w'(buffer_size - 1);
  localparam logic [idx_w:0]         size_lim     = (idx_w + 1)'(buffer_size);
  localparam logic [buffer_size-1:0] one_hot_base = buffer_size'(1);

  state_e                  state_q, state_d;
  logic [buf_w-1:0]        buf_q, buf_d;
  logic [idx_w-1:0]        idx_q, idx_d;
  logic [idx_w-1:0]        rem_q, rem_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  logic [buf_w-1:0]        bufp_q, bufp_d;
  logic [buffer_size-1:0]  fieldp_q, fieldp_d;
  logic [buffer_size-1:0]  fieldwp_q, fieldwp_d;
  logic [buffer_width-1:0] field_in_q, field_in_d;
  logic                    write_q, write_d;

  logic                    first_ok;
  logic                    accept;

  assign first_ok = ({1'b0, load_first} < size_lim);

  // The loader yields to any pat write and, unless allowed, to the buffer pat is addressing.
  assign s_ready = (state_q == ST_LOAD) && !pat_field_write &&
                   (allow_live || (pat_bufp != buf_q));
  assign accept  = s_valid && s_ready;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    state_d = state_q;
    buf_d   = buf_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    err_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (load_start) begin
          if (!first_ok) begin
            err_d = 1'b1;
          end else if (load_count == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_LOAD;
            buf_d   = load_buf;
            idx_d   = load_first;
            rem_d   = load_count;
          end
        end
      end
      ST_LOAD: begin
        if (accept) begin
          idx_d = (idx_q == last_idx) ? '0 : idx_q + 1'b1;
          rem_d = rem_q - 1'b1;
          if (rem_q == idx_w'(1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_comb begin
    // The pat read pointer is passed through untouched; only the write side is shared.
    fieldp_d   = pat_fieldp;
    bufp_d     = pat_bufp;
    fieldwp_d  = pat_fieldwp;
    field_in_d = pat_field_in;
    write_d    = pat_field_write;
    if (accept) begin
      bufp_d     = buf_q;
      fieldwp_d  = one_hot_base << idx_q;
      field_in_d = s_data;
      write_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      buf_q      <= '0;
      idx_q      <= '0;
      rem_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      bufp_q     <= '0;
      fieldp_q   <= '0;
      fieldwp_q  <= '0;
      field_in_q <= '0;
      write_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every register samples the pre-edge value of the others.
      state_q    <= state_d;
      buf_q      <= buf_d;
      idx_q      <= idx_d;
      rem_q      <= rem_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      bufp_q     <= bufp_d;
      fieldp_q   <= fieldp_d;
      fieldwp_q  <= fieldwp_d;
      field_in_q <= field_in_d;
      write_q    <= write_d;
    end
  end

  assign load_busy       = busy_q;
  assign load_done       = done_q;
  assign load_err        = err_q;
  assign bufp_out        = bufp_q;
  assign fieldp_out      = fieldp_q;
  assign fieldwp_out     = fieldwp_q;
  assign field_in_out    = field_in_q;
  assign field_write_out = write_q;

endmodule

// File: tb/tb_pattern_load_sched.sv
// Self-checking bench for pattern_load_sched: a queue-based model of the pending field run,
// checked every cycle, plus literal expectations for each directed scenario.
module tb_pattern_load_sched;

  localparam int BS = 22;
  localparam int BW = 8;
  localparam int IW = 5;

  logic          clk, rst;
  logic [2:0]    pat_bufp;
  logic [BS-1:0] pat_fieldp, pat_fieldwp;
  logic [BW-1:0] pat_field_in;
  logic          pat_field_write;
  logic          load_start;
  logic [2:0]    load_buf;
  logic [IW-1:0] load_first, load_count;
  logic [BW-1:0] s_data;
  logic          s_valid;
  logic          s_ready, load_busy, load_done, load_err;
  logic [2:0]    bufp_out;
  logic [BS-1:0] fieldp_out, fieldwp_out;
  logic [BW-1:0] field_in_out;
  logic          field_write_out;

  pattern_load_sched #(
    .buffer_size (BS),
    .buffer_width(BW),
    .no_bufs     (8),
    .idx_w       (IW),
    .allow_live  (1'b0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pat_bufp       (pat_bufp),
    .pat_fieldp     (pat_fieldp),
    .pat_fieldwp    (pat_fieldwp),
    .pat_field_in   (pat_field_in),
    .pat_field_write(pat_field_write),
    .load_start     (load_start),
    .load_buf       (load_buf),
    .load_first     (load_first),
    .load_count     (load_count),
    .s_data         (s_data),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .load_busy      (load_busy),
    .load_done      (load_done),
    .load_err       (load_err),
    .bufp_out       (bufp_out),
    .fieldp_out     (fieldp_out),
    .fieldwp_out    (fieldwp_out),
    .field_in_out   (field_in_out),
    .field_write_out(field_write_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: the load is a queue of field indices still to be written.
  int            m_mode = 0;  // 0 idle, 1 loading, 2 done
  logic [2:0]    m_buf  = '0;
  int            pend[$];
  bit            m_acc;
  logic [2:0]    e_bufp     = '0;
  logic [BS-1:0] e_fieldp   = '0;
  logic [BS-1:0] e_fieldwp  = '0;
  logic [BW-1:0] e_field_in = '0;
  logic          e_write = 1'b0, e_busy = 1'b0, e_done = 1'b0, e_err = 1'b0;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_mode = 0; m_buf = '0; pend.delete();
        e_bufp = '0; e_fieldp = '0; e_fieldwp = '0; e_field_in = '0;
        e_write = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_err = 1'b0;
      end else begin
        m_acc    = (m_mode == 1) && s_valid && !pat_field_write && (pat_bufp != m_buf);
        e_fieldp = pat_fieldp;
        e_err    = 1'b0;
        if (m_acc) begin
          e_bufp = m_buf; e_fieldwp = '0; e_fieldwp[pend[0]] = 1'b1;
          e_field_in = s_data; e_write = 1'b1;
        end else begin
          e_bufp = pat_bufp; e_fieldwp = pat_fieldwp;
          e_field_in = pat_field_in; e_write = pat_field_write;
        end
        case (m_mode)
          0: if (load_start) begin
            if (int'(load_first) >= BS) e_err = 1'b1;
            else if (load_count == 0) m_mode = 2;
            else begin
              m_mode = 1; m_buf = load_buf;
              for (int k = 0; k < int'(load_count); k++) pend.push_back((int'(load_first) + k) % BS);
            end
          end
          1: if (m_acc) begin
            void'(pend.pop_front());
            if (pend.size() == 0) m_mode = 2;
          end
          default: m_mode = 0;
        endcase
        e_busy = (m_mode != 0);
        e_done = (m_mode == 2);
      end
    end
  end

  typedef struct {
    logic [2:0]    b;
    logic [BS-1:0] wp;
    logic [BW-1:0] d;
  } wr_t;

  wr_t wr_log[$];
  int  done_cnt = 0, err_cnt = 0, busy_cnt = 0, low_cnt = 0;

  // Compare process: one sample per cycle, mid-low-phase.
  initial begin
    wr_t w;
    forever begin
      @(negedge clk);
      #2;
      check("s_ready", 64'(s_ready), 64'((m_mode == 1) && !pat_field_write && (pat_bufp != m_buf)));
      check("load_busy", 64'(load_busy), 64'(e_busy));
      check("load_done", 64'(load_done), 64'(e_done));
      check("load_err", 64'(load_err), 64'(e_err));
      check("bufp_out", 64'(bufp_out), 64'(e_bufp));
      check("fieldp_out", 64'(fieldp_out), 64'(e_fieldp));
      check("fieldwp_out", 64'(fieldwp_out), 64'(e_fieldwp));
      check("field_in_out", 64'(field_in_out), 64'(e_field_in));
      check("field_write_out", 64'(field_write_out), 64'(e_write));
      if (field_write_out === 1'b1) begin
        w.b = bufp_out; w.wp = fieldwp_out; w.d = field_in_out;
        wr_log.push_back(w);
      end
      if (load_done === 1'b1) done_cnt++;
      if (load_err === 1'b1) err_cnt++;
      if (load_busy === 1'b1) busy_cnt++;
      if (load_busy === 1'b1 && load_done === 1'b0 && s_ready === 1'b0) low_cnt++;
    end
  end

  task automatic clear_counts();
    wr_log.delete();
    done_cnt = 0; err_cnt = 0; busy_cnt = 0; low_cnt = 0;
  endtask

  task automatic start_load(input logic [2:0] b, input logic [IW-1:0] f, input logic [IW-1:0] c);
    @(negedge clk);
    load_start = 1'b1; load_buf = b; load_first = f; load_count = c;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d);
    int n;
    n = 0;
    @(negedge clk);
    s_valid = 1'b1; s_data = d;
    #1;
    while (!s_ready && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("send_ready", 64'(s_ready), 64'(1));
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (load_busy && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("idle_reached", 64'(load_busy), 64'(0));
    @(negedge clk);
    #3;
  endtask

  task automatic expect_write(input string tag, input int i, input logic [2:0] b,
                              input int f, input logic [7:0] d);
    logic [BS-1:0] oh;
    oh = '0;
    oh[f] = 1'b1;
    if (i < wr_log.size()) begin
      check({tag, "_bufp"}, 64'(wr_log[i].b), 64'(b));
      check({tag, "_wp"}, 64'(wr_log[i].wp), 64'(oh));
      check({tag, "_data"}, 64'(wr_log[i].d), 64'(d));
    end else begin
      check({tag, "_present"}, 64'(wr_log.size()), 64'(i + 1));
    end
  endtask

  initial begin
    wr_t tmp[$];
    int  pw;

    rst = 1'b1;
    pat_bufp = 3'd0; pat_fieldp = 22'h000100; pat_fieldwp = 22'h000004;
    pat_field_in = 8'h5A; pat_field_write = 1'b0;
    load_start = 1'b0; load_buf = '0; load_first = '0; load_count = '0;
    s_data = '0; s_valid = 1'b0;
    #1;
    check("rst_s_ready", 64'(s_ready), 64'(0));
    check("rst_busy", 64'(load_busy), 64'(0));
    check("rst_done", 64'(load_done), 64'(0));
    check("rst_err", 64'(load_err), 64'(0));
    check("rst_bufp", 64'(bufp_out), 64'(0));
    check("rst_fieldp", 64'(fieldp_out), 64'(0));
    check("rst_fieldwp", 64'(fieldwp_out), 64'(0));
    check("rst_field_in", 64'(field_in_out), 64'(0));
    check("rst_write", 64'(field_write_out), 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Full buffer, one byte per cycle.
    clear_counts();
    start_load(3'd3, 5'd0, 5'd22);
    for (int k = 0; k < 22; k++) send_byte(8'(8'h40 + k));
    check("t1_done_after_last", 64'(load_done), 64'(1));
    check("t1_last_write", 64'(field_write_out), 64'(1));
    wait_idle();
    check("t1_write_count", 64'(wr_log.size()), 64'(22));
    check("t1_done_pulses", 64'(done_cnt), 64'(1));
    for (int k = 0; k < 22; k++) expect_write("t1", k, 3'd3, k, 8'(8'h40 + k));

    // Wrapping run.
    clear_counts();
    start_load(3'd1, 5'd20, 5'd4);
    for (int k = 0; k < 4; k++) send_byte(8'(8'hA0 + k));
    wait_idle();
    check("t2_write_count", 64'(wr_log.size()), 64'(4));
    check("t2_done_pulses", 64'(done_cnt), 64'(1));
    expect_write("t2_w0", 0, 3'd1, 20, 8'hA0);
    expect_write("t2_w1", 1, 3'd1, 21, 8'hA1);
    expect_write("t2_w2", 2, 3'd1, 0, 8'hA2);
    expect_write("t2_w3", 3, 3'd1, 1, 8'hA3);

    // Pat writes interleaved with a load.
    clear_counts();
    start_load(3'd2, 5'd5, 5'd6);
    fork
      begin
        for (int k = 0; k < 6; k++) send_byte(8'(8'hB0 + k));
      end
      begin
        repeat (2) @(negedge clk);
        pat_field_write = 1'b1; pat_fieldwp = 22'h000800; pat_field_in = 8'hC3;
        repeat (3) @(negedge clk);
        pat_field_write = 1'b0; pat_fieldwp = 22'h000004; pat_field_in = 8'h5A;
      end
    join
    wait_idle();
    check("t3_ready_low_cycles", 64'(low_cnt), 64'(3));
    tmp = wr_log;
    wr_log.delete();
    pw = 0;
    foreach (tmp[k]) begin
      if (tmp[k].b == 3'd2) wr_log.push_back(tmp[k]);
      else begin
        pw++;
        check("t3_pat_wp", 64'(tmp[k].wp), 64'(22'h000800));
        check("t3_pat_data", 64'(tmp[k].d), 64'(8'hC3));
      end
    end
    check("t3_pat_writes", 64'(pw), 64'(3));
    check("t3_load_writes", 64'(wr_log.size()), 64'(6));
    for (int k = 0; k < 6; k++) expect_write("t3", k, 3'd2, 5 + k, 8'(8'hB0 + k));

    // Live-buffer protection.
    clear_counts();
    pat_bufp = 3'd5;
    start_load(3'd5, 5'd0, 5'd2);
    @(negedge clk);
    s_valid = 1'b1; s_data = 8'hC0;
    repeat (4) begin
      #1;
      check("t4_ready_blocked", 64'(s_ready), 64'(0));
      @(negedge clk);
    end
    s_valid = 1'b0;
    #3;
    check("t4_no_writes_blocked", 64'(wr_log.size()), 64'(0));
    pat_bufp = 3'd2;
    send_byte(8'hC0);
    send_byte(8'hC1);
    wait_idle();
    check("t4_write_count", 64'(wr_log.size()), 64'(2));
    expect_write("t4_w0", 0, 3'd5, 0, 8'hC0);
    expect_write("t4_w1", 1, 3'd5, 1, 8'hC1);
    pat_bufp = 3'd0;

    // Rejected start and empty run.
    clear_counts();
    start_load(3'd4, 5'd22, 5'd3);
    #1;
    check("t5_err_pulse", 64'(load_err), 64'(1));
    check("t5_err_busy", 64'(load_busy), 64'(0));
    repeat (3) @(negedge clk);
    #3;
    check("t5_err_count", 64'(err_cnt), 64'(1));
    check("t5_err_busy_cycles", 64'(busy_cnt), 64'(0));
    check("t5_err_writes", 64'(wr_log.size()), 64'(0));
    clear_counts();
    start_load(3'd4, 5'd3, 5'd0);
    #1;
    check("t5_zero_done", 64'(load_done), 64'(1));
    check("t5_zero_busy", 64'(load_busy), 64'(1));
    repeat (3) @(negedge clk);
    #3;
    check("t5_zero_done_count", 64'(done_cnt), 64'(1));
    check("t5_zero_busy_cycles", 64'(busy_cnt), 64'(1));
    check("t5_zero_writes", 64'(wr_log.size()), 64'(0));
    check("t5_zero_err", 64'(err_cnt), 64'(0));

    // Reset in the middle of a load, then a clean restart.
    clear_counts();
    start_load(3'd6, 5'd15, 5'd10);
    for (int k = 0; k < 5; k++) send_byte(8'(8'hE0 + k));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t6_rst_write", 64'(field_write_out), 64'(0));
    check("t6_rst_bufp", 64'(bufp_out), 64'(0));
    check("t6_rst_fieldwp", 64'(fieldwp_out), 64'(0));
    check("t6_rst_fieldp", 64'(fieldp_out), 64'(0));
    check("t6_rst_field_in", 64'(field_in_out), 64'(0));
    check("t6_rst_busy", 64'(load_busy), 64'(0));
    check("t6_rst_ready", 64'(s_ready), 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #3;
    check("t6_partial_writes", 64'(wr_log.size()), 64'(5));
    check("t6_no_done", 64'(done_cnt), 64'(0));
    expect_write("t6_w4", 4, 3'd6, 19, 8'hE4);
    clear_counts();
    start_load(3'd7, 5'd21, 5'd3);
    for (int k = 0; k < 3; k++) send_byte(8'(8'hD0 + k));
    wait_idle();
    check("t6_restart_writes", 64'(wr_log.size()), 64'(3));
    check("t6_restart_done", 64'(done_cnt), 64'(1));
    expect_write("t6_r0", 0, 3'd7, 21, 8'hD0);
    expect_write("t6_r1", 1, 3'd7, 0, 8'hD1);
    expect_write("t6_r2", 2, 3'd7, 1, 8'hD2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
